alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synthesizable self-checking consumer for the 8-bit ALU. It accepts one ALU transaction per cycle over a valid/ready handshake: operands, opcode and the result the ALU produced. It recomputes the expected result, compares the two, and keeps pass/fail counters and a sticky record of the first mismatch. It sits on the result side of `alu_8_bit`, opposite the stimulus source, and lets regression and on-chip self-test runs check ALU behaviour without a simulator-side scoreboard.

## Interface
- `STOP_ON_FAIL`, default 0: when 1, the checker halts intake after the first mismatch until `clear`.
- `CNT_W`, default 16: width of the pass and fail counters.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `clear` in 1: synchronous soft clear of counters, error record and halt state.
- `in_valid` in 1: the transaction on `in_*` is valid.
- `in_ready` out 1: the checker can accept a transaction.
- `in_a` in 8: operand a.
- `in_b` in 8: operand b.
- `in_op` in 2: ALU opcode.
- `in_result` in 8: result produced by the ALU under test.
- `pass_count` out CNT_W: number of matching transactions.
- `fail_count` out CNT_W: number of mismatching transactions.
- `err_valid` out 1: sticky flag; a mismatch has been recorded.
- `err_a`, `err_b` out 8 each: operands of the first mismatch.
- `err_op` out 2: opcode of the first mismatch.
- `err_expected` out 8: golden result of the first mismatch.
- `err_got` out 8: ALU result of the first mismatch.
- `halted` out 1: high in the HALTED state.

## Operation
- Opcode map:
  - 00: ADD, (a+b) mod 256.
  - 01: SUB, (a−b) mod 256, two's complement wrap.
  - 10: AND.
  - 11: OR.
- All arithmetic is unsigned 8-bit. Carry and borrow are discarded.
- Two-stage pipeline:
  - S1 registers the accepted transaction and its expected value.
  - The update stage compares S1 and updates the counters and error record.
- FSM has two states:
  - RUN: normal intake.
  - HALTED: entered only when `STOP_ON_FAIL`=1 and the update stage sees a mismatch. Left only by `clear` or `rst`.
- `in_ready` = (state==RUN) && !clear && !(STOP_ON_FAIL && S1 valid && S1 mismatch). With STOP_ON_FAIL=1, no transaction after a failing one is accepted.
- Acceptance: `in_valid && in_ready` at a rising edge. Inputs are sampled only then. `in_valid` without `in_ready` holds nothing; the source must keep its data stable.
- Counters saturate at 2^CNT_W−1 and never wrap. A saturated counter holds while the other counter keeps counting.
- Error record is loaded only by the first mismatch (`err_valid`=0→1). Later mismatches increment `fail_count` only.
- `clear` behaviour:
  - Zeroes both counters, `err_valid`, all `err_*` fields and `halted`.
  - Drops any S1 transaction uncounted.
  - Returns the FSM to RUN.
  - Has priority over a same-cycle acceptance; `in_ready` is already 0.
- `rst` has the same effect as `clear`. Reset values: `in_ready` 0 during rst and 1 on the first cycle after. All other outputs 0.

## Timing
- Latency: a transaction accepted at edge N updates `pass_count`/`fail_count`/`err_*` at edge N+1. The new values are visible in the cycle after edge N+1.
- Throughput: one transaction per cycle while in RUN with no pending failure.
- `halted` rises at the same edge that increments `fail_count` for the failing transaction.
- `in_ready` falls combinationally in the cycle in which the failing transaction sits in S1 (STOP_ON_FAIL=1).
- `rst` or `clear` asserted mid-stream: the in-flight S1 transaction is lost, and outputs are zero in the cycle after the edge.
- Simultaneous saturation and mismatch: `fail_count` holds, and the error record is still captured if it is the first mismatch.

## Test plan
- Stream back-to-back with in_valid held high, one transaction per cycle:
  - Stimulus: a=CC b=AA op00 res=76; a=CC b=AA op01 res=22; a=55 b=33 op10 res=11; a=F0 b=CC op11 res=FC.
  - Required: pass_count=4 two cycles after the last accept, fail_count=0, err_valid=0.
- STOP_ON_FAIL=0, corrupted result:
  - Stimulus: a=CC b=AA op00 res=77, then a=01 b=02 op00 res=00.
  - Required: fail_count=2, err_valid=1, err_expected=76, err_got=77, err_op=00. The record is not overwritten by the second failure.
- STOP_ON_FAIL=1, failure then more traffic:
  - Stimulus: a=00 b=01 op01 res=00, followed by valid transactions.
  - Required: err_expected=FF, halted=1, in_ready=0 from the cycle after the failing accept. No further counts.
  - Then pulse clear: all counters and err fields become 0, halted=0, in_ready=1.
- Saturation with CNT_W=2:
  - Stimulus: 5 passing transactions, then 1 failing.
  - Required: pass_count holds at 3, fail_count=1.
- Mid-stream events:
  - Accept a passing transaction, then assert rst the next cycle: pass_count stays 0.
  - Assert clear and in_valid in the same cycle: in_ready=0 and no transaction is counted.

Source files
------------

// File: rtl/alu_result_checker.sv
// Result-side checker for the 8-bit ALU: recomputes each accepted result, keeps
// saturating pass/fail counts and a sticky record of the first mismatch.
module alu_result_checker #(
  parameter int STOP_ON_FAIL = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_result,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_valid,
  output logic [7:0]       err_a,
  output logic [7:0]       err_b,
  output logic [1:0]       err_op,
  output logic [7:0]       err_expected,
  output logic [7:0]       err_got,
  output logic             halted
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             STOP    = (STOP_ON_FAIL != 0);

  state_t     state;
  logic       s1_valid;
  logic [7:0] s1_a, s1_b, s1_exp, s1_got;
  logic [1:0] s1_op;
  logic       s1_fail;
  logic       accept;
  logic [7:0] golden;

  always_comb begin
    golden = 8'h00;
    case (in_op)
      2'b00: golden = in_a + in_b;
      2'b01: golden = in_a - in_b;
      2'b10: golden = in_a & in_b;
      2'b11: golden = in_a | in_b;
      default: golden = 8'h00;
    endcase
  end

  assign s1_fail = s1_valid && (s1_exp != s1_got);

  // Holding off intake while a failure sits in S1 keeps the stream frozen
  // exactly at the failing transaction when halting is enabled.
  assign in_ready = !rst && (state == RUN) && !clear && !(STOP && s1_fail);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= RUN;
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_op        <= '0;
      s1_exp       <= '0;
      s1_got       <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      err_valid    <= 1'b0;
      err_a        <= '0;
      err_b        <= '0;
      err_op       <= '0;
      err_expected <= '0;
      err_got      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_exp <= golden;
        s1_got <= in_result;
      end
      if (s1_valid) begin
        if (!s1_fail) begin
          if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
        end else begin
          if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
          if (!err_valid) begin
            err_valid    <= 1'b1;
            err_a        <= s1_a;
            err_b        <= s1_b;
            err_op       <= s1_op;
            err_expected <= s1_exp;
            err_got      <= s1_got;
          end
          if (STOP) state <= HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench: three checker instances (free-running, halt-on-fail, 2-bit counters)
// compared every cycle against a transaction-level model, plus directed cases.
module tb_alu_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear;
  logic [7:0] a, b, res;
  logic [1:0] op;
  logic [2:0] vld;

  logic        rdy0, rdy1, rdy2;
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [1:0]  pc2, fc2;
  logic        ev0, ev1, ev2, hl0, hl1, hl2;
  logic [7:0]  ea0, eb0, ee0, eg0, ea1, eb1, ee1, eg1, ea2, eb2, ee2, eg2;
  logic [1:0]  eo0, eo1, eo2;

  alu_result_checker #(.STOP_ON_FAIL(0), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(vld[0]), .in_ready(rdy0),
    .in_a(a), .in_b(b), .in_op(op), .in_result(res),
    .pass_count(pc0), .fail_count(fc0), .err_valid(ev0), .err_a(ea0), .err_b(eb0),
    .err_op(eo0), .err_expected(ee0), .err_got(eg0), .halted(hl0));

  alu_result_checker #(.STOP_ON_FAIL(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(vld[1]), .in_ready(rdy1),
    .in_a(a), .in_b(b), .in_op(op), .in_result(res),
    .pass_count(pc1), .fail_count(fc1), .err_valid(ev1), .err_a(ea1), .err_b(eb1),
    .err_op(eo1), .err_expected(ee1), .err_got(eg1), .halted(hl1));

  alu_result_checker #(.STOP_ON_FAIL(0), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(vld[2]), .in_ready(rdy2),
    .in_a(a), .in_b(b), .in_op(op), .in_result(res),
    .pass_count(pc2), .fail_count(fc2), .err_valid(ev2), .err_a(ea2), .err_b(eb2),
    .err_op(eo2), .err_expected(ee2), .err_got(eg2), .halted(hl2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gold(input int x, input int y, input int o);
    case (o)
      0: return (x + y) % 256;
      1: return (x - y + 256) % 256;
      2: return x & y;
      default: return x | y;
    endcase
  endfunction

  // Transaction-level model: a pending slot resolves one edge after acceptance.
  int m_pass[3], m_fail[3], m_ev[3], m_ea[3], m_eb[3], m_eo[3], m_ee[3], m_eg[3], m_halt[3];
  int p_v[3], p_a[3], p_b[3], p_o[3], p_exp[3], p_got[3];

  function automatic int max_cnt(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic bit m_ready(input int k);
    bit stall;
    stall = (k == 1) && (p_v[k] != 0) && (p_exp[k] != p_got[k]);
    return !rst && !clear && (m_halt[k] == 0) && !stall;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    for (int k = 0; k < 3; k++) begin
      if (rst || clear) begin
        m_pass[k] = 0; m_fail[k] = 0; m_ev[k] = 0; m_ea[k] = 0; m_eb[k] = 0;
        m_eo[k] = 0; m_ee[k] = 0; m_eg[k] = 0; m_halt[k] = 0; p_v[k] = 0;
      end else begin
        acc = vld[k] && m_ready(k);
        if (p_v[k] != 0) begin
          if (p_exp[k] == p_got[k]) begin
            if (m_pass[k] < max_cnt(k)) m_pass[k]++;
          end else begin
            if (m_fail[k] < max_cnt(k)) m_fail[k]++;
            if (m_ev[k] == 0) begin
              m_ev[k] = 1; m_ea[k] = p_a[k]; m_eb[k] = p_b[k]; m_eo[k] = p_o[k];
              m_ee[k] = p_exp[k]; m_eg[k] = p_got[k];
            end
            if (k == 1) m_halt[k] = 1;
          end
        end
        p_v[k] = acc;
        if (acc) begin
          p_a[k] = a; p_b[k] = b; p_o[k] = op; p_got[k] = res;
          p_exp[k] = gold(a, b, op);
        end
      end
    end
  end

  task automatic check_dut(input int k, input logic r, input logic [15:0] p, input logic [15:0] f,
                           input logic e, input logic [7:0] xa, input logic [7:0] xb,
                           input logic [1:0] xo, input logic [7:0] xe, input logic [7:0] xg,
                           input logic h);
    chk($sformatf("d%0d.in_ready", k), r, m_ready(k));
    chk($sformatf("d%0d.pass_count", k), p, m_pass[k]);
    chk($sformatf("d%0d.fail_count", k), f, m_fail[k]);
    chk($sformatf("d%0d.err_valid", k), e, m_ev[k]);
    chk($sformatf("d%0d.err_a", k), xa, m_ea[k]);
    chk($sformatf("d%0d.err_b", k), xb, m_eb[k]);
    chk($sformatf("d%0d.err_op", k), xo, m_eo[k]);
    chk($sformatf("d%0d.err_expected", k), xe, m_ee[k]);
    chk($sformatf("d%0d.err_got", k), xg, m_eg[k]);
    chk($sformatf("d%0d.halted", k), h, m_halt[k]);
  endtask

  task automatic step();
    @(negedge clk);
    check_dut(0, rdy0, pc0, fc0, ev0, ea0, eb0, eo0, ee0, eg0, hl0);
    check_dut(1, rdy1, pc1, fc1, ev1, ea1, eb1, eo1, ee1, eg1, hl1);
    check_dut(2, rdy2, {14'b0, pc2}, {14'b0, fc2}, ev2, ea2, eb2, eo2, ee2, eg2, hl2);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] xa, input logic [7:0] xb,
                      input logic [1:0] xo, input logic [7:0] xr);
    a = xa; b = xb; op = xo; res = xr;
    vld = 3'b000;
    vld[k] = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    vld = 3'b000;
    repeat (n) step();
  endtask

  task automatic do_clear();
    vld = 3'b000;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; vld = 3'b000; a = 0; b = 0; op = 0; res = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_ready", rdy0, 1'b1);
    chk("reset_pass", pc0, 16'd0);
    chk("reset_errv", ev0, 1'b0);

    // Back-to-back passing stream
    send(0, 8'hCC, 8'hAA, 2'b00, 8'h76);
    send(0, 8'hCC, 8'hAA, 2'b01, 8'h22);
    send(0, 8'h55, 8'h33, 2'b10, 8'h11);
    send(0, 8'hF0, 8'hCC, 2'b11, 8'hFC);
    idle(2);
    chk("stream_pass", pc0, 16'd4);
    chk("stream_fail", fc0, 16'd0);
    chk("stream_errv", ev0, 1'b0);

    // Two failures, record keeps the first
    do_clear();
    send(0, 8'hCC, 8'hAA, 2'b00, 8'h77);
    send(0, 8'h01, 8'h02, 2'b00, 8'h00);
    idle(2);
    chk("nostop_fail", fc0, 16'd2);
    chk("nostop_errv", ev0, 1'b1);
    chk("nostop_exp", ee0, 8'h76);
    chk("nostop_got", eg0, 8'h77);
    chk("nostop_op", eo0, 2'b00);
    chk("nostop_a", ea0, 8'hCC);

    // Halt on failure, then clear
    send(1, 8'h00, 8'h01, 2'b01, 8'h00);
    repeat (4) send(1, 8'h03, 8'h04, 2'b00, 8'h07);
    chk("halt_halted", hl1, 1'b1);
    chk("halt_exp", ee1, 8'hFF);
    chk("halt_ready", rdy1, 1'b0);
    chk("halt_pass", pc1, 16'd0);
    chk("halt_fail", fc1, 16'd1);
    do_clear();
    vld = 3'b010;
    #1;
    chk("clr_ready", rdy1, 1'b1);
    chk("clr_halted", hl1, 1'b0);
    chk("clr_fail", fc1, 16'd0);
    chk("clr_errv", ev1, 1'b0);
    chk("clr_exp", ee1, 8'h00);
    chk("clr_got", eg1, 8'h00);
    vld = 3'b000;

    // Saturation on the 2-bit instance
    repeat (5) send(2, 8'h10, 8'h20, 2'b00, 8'h30);
    send(2, 8'h10, 8'h20, 2'b11, 8'h00);
    idle(2);
    chk("sat_pass", pc2, 2'd3);
    chk("sat_fail", fc2, 2'd1);
    chk("sat_errv", ev2, 1'b1);

    // Reset right after an accept drops it
    do_clear();
    send(0, 8'h01, 8'h01, 2'b00, 8'h02);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    chk("rst_mid_pass", pc0, 16'd0);

    // Clear with valid in the same cycle
    a = 8'h02; b = 8'h02; op = 2'b00; res = 8'h04;
    clear = 1'b1; vld = 3'b001;
    #1;
    chk("clrv_ready", rdy0, 1'b0);
    step();
    clear = 1'b0;
    idle(3);
    chk("clrv_pass", pc0, 16'd0);
    chk("clrv_fail", fc0, 16'd0);

    // Randomized traffic on all instances
    repeat (300) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      res = ($urandom_range(3) != 0) ? 8'(gold(a, b, op)) : 8'($urandom);
      vld = 3'($urandom);
      clear = ($urandom_range(39) == 0);
      step();
    end
    clear = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
